// File: rtl/dct_block_scheduler_pkg.sv
// Shared types and default geometry for the DCT block scheduler.
package dct_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    PRESENT,
    DONE
  } sched_state_e;

  localparam int unsigned BLK        = 8;
  localparam int unsigned MCU_BYTES  = BLK * BLK;
  localparam int unsigned DEF_IMG_W  = 224;
  localparam int unsigned DEF_IMG_H  = 224;
  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned MCU_W      = MCU_BYTES * DEF_PIX_W;
  localparam int unsigned BLKS_X     = DEF_IMG_W / BLK;
  localparam int unsigned NUM_BLOCKS = (DEF_IMG_W / BLK) * (DEF_IMG_H / BLK);

endpackage

// File: rtl/dct_block_scheduler_mcu_addr_gen.sv
// Raster-block pixel address generator: row/col counters inside a block plus
// block-column/block-row counters, all advanced by adders only.
module mcu_addr_gen
  import dct_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = 224,
  parameter int unsigned IMG_H  = 224,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              next_block,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pix,
  output logic              last_blk
);

  localparam int unsigned NBX = IMG_W / BLK;
  localparam int unsigned NBY = IMG_H / BLK;
  localparam int unsigned BXW = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int unsigned BYW = (NBY > 1) ? $clog2(NBY) : 1;
  localparam int unsigned PW  = $clog2(BLK);

  localparam logic [PW-1:0]     CMAX      = PW'(BLK - 1);
  localparam logic [BXW-1:0]    BX_LAST   = BXW'(NBX - 1);
  localparam logic [BYW-1:0]    BY_LAST   = BYW'(NBY - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(BLK);
  // From the top-left of the last block in a band to the first block of the next band.
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'((BLK - 1) * IMG_W + BLK);

  logic [BXW-1:0]    bx;
  logic [BYW-1:0]    by;
  logic [PW-1:0]     r;
  logic [PW-1:0]     c;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] next_row;

  assign last_pix = (r == CMAX) && (c == CMAX);
  assign last_blk = (bx == BX_LAST) && (by == BY_LAST);

  always_comb begin
    next_base = base + BLK_STEP;
    next_row  = row_base + ROW_STEP;
    if (bx == BX_LAST) begin
      next_base = base + BAND_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || load) begin
      bx       <= '0;
      by       <= '0;
      r        <= '0;
      c        <= '0;
      base     <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (step) begin
      if (c == CMAX) begin
        c        <= '0;
        r        <= r + 1'b1;
        row_base <= next_row;
        addr     <= next_row;
      end else begin
        c    <= c + 1'b1;
        addr <= addr + 1'b1;
      end
    end else if (next_block) begin
      r        <= '0;
      c        <= '0;
      base     <= next_base;
      row_base <= next_base;
      addr     <= next_base;
      if (bx == BX_LAST) begin
        bx <= '0;
        by <= by + 1'b1;
      end else begin
        bx <= bx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// Walks the frozen luma buffer in raster block order and hands 8x8 MCUs to the DCT stage.
// Optional frame cycle counter enabled by defining DCT_SCHED_PERF_EN.
module dct_block_scheduler
  import dct_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = 224,
  parameter int unsigned IMG_H  = 224,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       pix_rd_en,
  output logic [ADDR_W-1:0]          pix_rd_addr,
  input  logic [PIX_W-1:0]           pix_rd_data,
  output logic [MCU_BYTES*PIX_W-1:0] mcu,
  output logic                       mcu_valid,
  input  logic                       mcu_ready,
  output logic [9:0]                 block_idx,
  output logic [31:0]                perf_cycles
);

  if (((IMG_W % BLK) != 0) || ((IMG_H % BLK) != 0)) begin : g_bad_dims
    $error("dct_block_scheduler: IMG_W and IMG_H must be multiples of BLK");
  end
  if ((IMG_W * IMG_H - 1) >= (2 ** ADDR_W)) begin : g_bad_addr
    $error("dct_block_scheduler: ADDR_W too narrow for IMG_W*IMG_H");
  end

  sched_state_e state;
  logic         rd_pend;
  logic [5:0]   cap_idx;
  logic         last_pix;
  logic         last_blk;
  logic         accept;
  logic         kill;
  logic         ag_load;
  logic         ag_step;
  logic         ag_next;

  assign accept  = (state == IDLE) && start && !abort;
  assign kill    = (state != IDLE) && abort;
  assign ag_load = accept || kill;
  assign ag_step = (state == FETCH) && !abort && !last_pix;
  assign ag_next = (state == PRESENT) && !abort && mcu_ready && !last_blk;

  mcu_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (ag_load),
    .step       (ag_step),
    .next_block (ag_next),
    .addr       (pix_rd_addr),
    .last_pix   (last_pix),
    .last_blk   (last_blk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_rd_en <= 1'b0;
      mcu_valid <= 1'b0;
      block_idx <= '0;
      mcu       <= '0;
      rd_pend   <= 1'b0;
      cap_idx   <= '0;
    end else begin
      done    <= 1'b0;
      // Read data trails the strobe by one cycle; byte k lands one cycle after its address.
      rd_pend <= pix_rd_en && !abort;
      if (rd_pend && !abort) begin
        mcu[cap_idx*PIX_W +: PIX_W] <= pix_rd_data;
        cap_idx                     <= cap_idx + 1'b1;
      end

      if (kill) begin
        state     <= IDLE;
        busy      <= 1'b0;
        pix_rd_en <= 1'b0;
        mcu_valid <= 1'b0;
        block_idx <= '0;
        cap_idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state     <= FETCH;
              busy      <= 1'b1;
              pix_rd_en <= 1'b1;
              block_idx <= '0;
              cap_idx   <= '0;
            end
          end
          FETCH: begin
            if (last_pix) begin
              state     <= CAPT;
              pix_rd_en <= 1'b0;
            end
          end
          CAPT: begin
            state     <= PRESENT;
            mcu_valid <= 1'b1;
          end
          PRESENT: begin
            if (mcu_ready) begin
              mcu_valid <= 1'b0;
              if (last_blk) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state     <= FETCH;
                pix_rd_en <= 1'b1;
                block_idx <= block_idx + 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DCT_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset || accept || kill) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Scoreboard bench for dct_block_scheduler: expected MCUs are queued at each start
// and popped by a monitor on every mcu_valid/mcu_ready handshake.
module tb_dct_block_scheduler;

  localparam int IMG_W = 224;
  localparam int NB    = 784;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic         pix_rd_en;
  logic [15:0]  pix_rd_addr;
  logic [7:0]   pix_rd_data = 8'h00;
  logic [511:0] mcu;
  logic         mcu_valid;
  logic         mcu_ready;
  logic [9:0]   block_idx;
  logic [31:0]  perf_cycles;

  dct_block_scheduler #(
    .IMG_W  (224),
    .IMG_H  (224),
    .PIX_W  (8),
    .ADDR_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .pix_rd_en   (pix_rd_en),
    .pix_rd_addr (pix_rd_addr),
    .pix_rd_data (pix_rd_data),
    .mcu         (mcu),
    .mcu_valid   (mcu_valid),
    .mcu_ready   (mcu_ready),
    .block_idx   (block_idx),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: data = addr[7:0], one cycle of read latency.
  always @(posedge clk) if (pix_rd_en) pix_rd_data <= pix_rd_addr[7:0];

  typedef struct {
    logic [9:0]   idx;
    logic [511:0] m;
  } exp_t;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  int           hs_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           first_hs_cyc = 0;
  logic [511:0] first_mcu = '0;
  bit           seen[NB];
  int           first_addr[NB];
  int           last_addr[NB];

  function automatic logic [511:0] exp_mcu(input int b);
    logic [511:0] m;
    int base, a;
    base = (b / 28) * 8 * IMG_W + (b % 28) * 8;
    m = '0;
    for (int k = 0; k < 64; k++) begin
      a = base + (k / 8) * IMG_W + (k % 8);
      m[8*k +: 8] = a[7:0];
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      e.idx = 10'(b);
      e.m   = exp_mcu(b);
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && mcu_valid && mcu_ready) begin
      hs_cnt++;
      if (hs_cnt == 1) begin
        first_hs_cyc = cyc;
        first_mcu    = mcu;
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_mcu: got idx %0d, expected no handshake", block_idx);
      end else begin
        e = q.pop_front();
        if (block_idx !== e.idx || mcu !== e.m) begin
          fails++;
          $display("FAIL mcu_blk%0d: got idx %0d mcu %h expected idx %0d mcu %h",
                   e.idx, block_idx, mcu, e.idx, e.m);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pix_rd_en && block_idx < NB) begin
      if (!seen[block_idx]) begin
        seen[block_idx]       = 1'b1;
        first_addr[block_idx] = int'(pix_rd_addr);
      end
      last_addr[block_idx] = int'(pix_rd_addr);
    end
  end

  initial begin
    int s, n, hb;
    reset = 1'b1; start = 1'b0; abort = 1'b0; mcu_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", pix_rd_en, 0);
    chk("rst_addr", pix_rd_addr, 0);
    chk("rst_valid", mcu_valid, 0);
    chk("rst_mcu", mcu, 0);
    chk("rst_idx", block_idx, 0);
    chk("rst_perf", perf_cycles, 0);
    reset = 1'b0;
    tick();

    // Frame 1: ready tied high, full timing.
    push_frame();
    start = 1'b1; s = cyc;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 60000) begin tick(); n++; end
    chk("f1_done_seen", done_cnt, 1);
    chk("f1_done_latency", done_cyc - s, 51745);
    chk("f1_busy_after", busy, 0);
    chk("f1_first_hs", first_hs_cyc - s, 66);
    chk("f1_handshakes", hs_cnt, 784);
    chk("f1_queue_empty", q.size(), 0);
    chk("f1_byte0", first_mcu[7:0], 8'h00);
    chk("f1_byte1", first_mcu[15:8], 8'h01);
    chk("f1_byte8", first_mcu[71:64], 8'hE0);
    chk("blk1_first", first_addr[1], 8);
    chk("blk29_first", first_addr[29], 1800);
    chk("blk29_last", last_addr[29], 3375);
    chk("blk783_first", first_addr[783], 48600);
    chk("blk783_last", last_addr[783], 50175);
`ifdef DCT_SCHED_PERF_EN
    chk("f1_perf", perf_cycles, 51745);
`else
    chk("f1_perf", perf_cycles, 0);
`endif

    // Frame 2: stall at block 0, stray start at block 3, abort inside block 5.
    mcu_ready = 1'b0;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!mcu_valid && n < 200) begin tick(); n++; end
    chk("f2_valid_seen", mcu_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ctl", {mcu_valid, pix_rd_en, block_idx}, {1'b1, 1'b0, 10'd0});
      chk("stall_mcu", mcu, exp_mcu(0));
      tick();
    end
    mcu_ready = 1'b1;
    tick();
    chk("blk1_fetch", {pix_rd_en, block_idx, pix_rd_addr}, {1'b1, 10'd1, 16'd8});

    n = 0;
    while (!(block_idx == 10'd3 && pix_rd_en) && n < 500) begin tick(); n++; end
    chk("reach_blk3", block_idx, 3);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;

    n = 0;
    while (!(block_idx == 10'd5 && pix_rd_en) && n < 500) begin tick(); n++; end
    repeat (10) tick();
    chk("blk5_fetching", {pix_rd_en, block_idx}, {1'b1, 10'd5});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {busy, pix_rd_en, mcu_valid, done, block_idx}, 14'd0);
    chk("abort_perf", perf_cycles, 0);
    q.delete();
    hb = hs_cnt;
    repeat (150) tick();
    chk("abort_no_hs", hs_cnt - hb, 0);
    chk("abort_no_done", done_cnt, 1);
    chk("hs_before_abort", hb, 784 + 5);

    // Frame 3: restart from block 0, then reset while presenting.
    mcu_ready = 1'b0;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart", {busy, pix_rd_en, block_idx, pix_rd_addr}, {1'b1, 1'b1, 10'd0, 16'd0});
    n = 0;
    while (!mcu_valid && n < 200) begin tick(); n++; end
    chk("f3_valid_seen", mcu_valid, 1);
    reset = 1'b1;
    tick();
    chk("midrst_ctl", {busy, done, pix_rd_en, mcu_valid, block_idx}, 14'd0);
    chk("midrst_addr", pix_rd_addr, 0);
    chk("midrst_mcu", mcu, 0);
    chk("midrst_perf", perf_cycles, 0);
    reset = 1'b0;
    q.delete();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
